// File: rtl/gpio_mmio_responder.sv
// Memory-mapped GPIO / device-output responder for the core's data-memory port.
// Optional: define GPIO_EDGE_FALL_EN to make EDGE flags capture falling edges too.
module gpio_mmio_responder #(
  parameter int          DATA_WIDTH     = 32,
  parameter logic [7:0]  RESET_GPIO_OUT = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Sel,
  input  logic [4:0]            Addr,
  input  logic                  Mem_Write,
  input  logic                  Mem_Read,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Ready,
  input  logic [7:0]            GPIO_In,
  output logic [7:0]            GPIO_Out,
  output logic [7:0]            Device_Out,
  output logic                  Device_Valid,
  input  logic                  Device_Ack
);

  typedef enum logic [2:0] {
    REG_GPIO_OUT = 3'd0,
    REG_GPIO_IN  = 3'd1,
    REG_EDGE     = 3'd2,
    REG_DEV_DATA = 3'd3,
    REG_STATUS   = 3'd4
  } reg_e;

  typedef enum logic {
    DEV_IDLE = 1'b0,
    DEV_PEND = 1'b1
  } dev_state_e;

  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  ready_q;
  logic [7:0]            gpio_out_q;
  logic [7:0]            sync1_q, sync2_q, sync3_q;
  logic [7:0]            edge_q, edge_d, edge_hit, edge_w1c;
  logic [7:0]            dev_data_q;
  logic                  ovf_q;
  dev_state_e            dev_state_q;
  reg_e                  reg_sel;
  logic                  rd_en, wr_en, dev_wr;
  logic [7:0]            rd_val;
  logic                  unused_bits;

  assign reg_sel = reg_e'(Addr[4:2]);
  assign rd_en   = Sel & Mem_Read;
  assign wr_en   = Sel & Mem_Write;
  assign dev_wr  = wr_en && (reg_sel == REG_DEV_DATA);

  // Byte lane offset and upper store bits carry no meaning for this block.
  assign unused_bits = &{1'b0, Addr[1:0], Write_Data[DATA_WIDTH-1:8]};

`ifdef GPIO_EDGE_FALL_EN
  assign edge_hit = sync2_q ^ sync3_q;
`else
  assign edge_hit = sync2_q & ~sync3_q;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_val   = 8'h00;
    edge_w1c = 8'h00;
    case (reg_sel)
      REG_GPIO_OUT: rd_val = gpio_out_q;
      REG_GPIO_IN:  rd_val = sync2_q;
      REG_EDGE:     rd_val = edge_q;
      REG_DEV_DATA: rd_val = dev_data_q;
      REG_STATUS:   rd_val = {6'b0, ovf_q, dev_state_q == DEV_PEND};
      default:      rd_val = 8'h00;
    endcase
    if (wr_en && reg_sel == REG_EDGE) edge_w1c = Write_Data[7:0];
    // A new edge wins over a same-cycle clear of that bit.
    edge_d = (edge_q & ~edge_w1c) | edge_hit;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
      ready_q     <= 1'b0;
      gpio_out_q  <= RESET_GPIO_OUT;
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      sync3_q     <= 8'h00;
      edge_q      <= 8'h00;
    end else begin
      ready_q <= Sel & (Mem_Read | Mem_Write);
      if (rd_en) read_data_q <= DATA_WIDTH'(rd_val);
      if (wr_en && reg_sel == REG_GPIO_OUT) gpio_out_q <= Write_Data[7:0];
      sync1_q <= GPIO_In;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= edge_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dev_state_q <= DEV_IDLE;
      dev_data_q  <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      if (wr_en && reg_sel == REG_STATUS && Write_Data[1]) ovf_q <= 1'b0;
      case (dev_state_q)
        DEV_IDLE: begin
          if (dev_wr) begin
            dev_data_q  <= Write_Data[7:0];
            dev_state_q <= DEV_PEND;
          end
        end
        DEV_PEND: begin
          if (Device_Ack) begin
            if (dev_wr) dev_data_q <= Write_Data[7:0];
            else        dev_state_q <= DEV_IDLE;
          end else if (dev_wr) begin
            // Byte still owned by the device: drop the store and flag it.
            ovf_q <= 1'b1;
          end
        end
        default: dev_state_q <= DEV_IDLE;
      endcase
    end
  end

  assign Read_Data    = read_data_q;
  assign Ready        = ready_q;
  assign GPIO_Out     = gpio_out_q;
  assign Device_Out   = dev_data_q;
  assign Device_Valid = (dev_state_q == DEV_PEND);

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Scoreboard bench for gpio_mmio_responder: accesses push expected responses,
// a monitor pops one per Ready pulse and compares Read_Data.
module tb_gpio_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        Sel;
  logic [4:0]  Addr;
  logic        Mem_Write, Mem_Read;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;
  logic        Ready;
  logic [7:0]  GPIO_In;
  logic [7:0]  GPIO_Out;
  logic [7:0]  Device_Out;
  logic        Device_Valid;
  logic        Device_Ack;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];

  gpio_mmio_responder #(.DATA_WIDTH(32), .RESET_GPIO_OUT(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .Sel          (Sel),
    .Addr         (Addr),
    .Mem_Write    (Mem_Write),
    .Mem_Read     (Mem_Read),
    .Write_Data   (Write_Data),
    .Read_Data    (Read_Data),
    .Ready        (Ready),
    .GPIO_In      (GPIO_In),
    .GPIO_Out     (GPIO_Out),
    .Device_Out   (Device_Out),
    .Device_Valid (Device_Valid),
    .Device_Ack   (Device_Ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one access for a single cycle starting at a falling edge; returns at the next falling edge.
  task automatic acc(input string name, input bit rd, input bit wr, input logic [4:0] a,
                     input logic [31:0] wdata, input logic [31:0] exp_rd);
    exp_t e;
    Sel        = 1'b1;
    Addr       = a;
    Mem_Read   = rd;
    Mem_Write  = wr;
    Write_Data = wdata;
    e.is_read  = rd;
    e.data     = exp_rd;
    e.name     = name;
    sb.push_back(e);
    @(negedge clk);
    Sel       = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp_rd);
    acc(name, 1'b1, 1'b0, a, 32'h0, exp_rd);
  endtask

  task automatic wr(input string name, input logic [4:0] a, input logic [31:0] wdata);
    acc(name, 1'b0, 1'b1, a, wdata, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: every Ready pulse must match one queued access.
  initial begin
    forever begin
      @(negedge clk);
      if (Ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_read) check(e.name, Read_Data, e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] edge_after_fall;
    reset = 1'b1; Sel = 1'b0; Addr = '0; Mem_Write = 1'b0; Mem_Read = 1'b0;
    Write_Data = '0; GPIO_In = 8'h00; Device_Ack = 1'b0;
    idle(3);
    reset = 1'b0;
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_read_data", Read_Data, 32'h0);
    check("rst_gpio_out", 32'(GPIO_Out), 32'h00);
    check("rst_dev_valid", 32'(Device_Valid), 32'd0);
    check("rst_dev_out", 32'(Device_Out), 32'h00);

    rd("rst_rd_gpio_out", 5'h00, 32'h0);
    rd("rst_rd_edge", 5'h08, 32'h0);
    rd("rst_rd_status", 5'h10, 32'h0);

    wr("wr_gpio_a5", 5'h00, 32'h0000_00A5);
    check("gpio_out_a5", 32'(GPIO_Out), 32'hA5);
    rd("rd_gpio_a5", 5'h00, 32'hA5);
    wr("wr_unmapped", 5'h18, 32'hFFFF_FFFF);
    rd("rd_unmapped", 5'h18, 32'h0);
    rd("rd_gpio_after_unmapped", 5'h00, 32'hA5);
    acc("rw_gpio_prewrite", 1'b1, 1'b1, 5'h00, 32'h5A, 32'hA5);
    check("gpio_out_5a", 32'(GPIO_Out), 32'h5A);
    rd("rd_gpio_5a", 5'h01, 32'h5A);

    // Input sync latency: reads sampled on edges N..N+3 after GPIO_In changes.
    GPIO_In = 8'h12;
    rd("gpio_in_n", 5'h04, 32'h00);
    rd("edge_n1", 5'h08, 32'h00);
    rd("gpio_in_n2", 5'h04, 32'h12);
    rd("edge_n3", 5'h08, 32'h12);
    wr("w1c_edge_02", 5'h08, 32'h02);
    rd("edge_after_w1c", 5'h08, 32'h10);
    GPIO_In = 8'h00;
    idle(5);
`ifdef GPIO_EDGE_FALL_EN
    edge_after_fall = 32'h12;
`else
    edge_after_fall = 32'h10;
`endif
    rd("edge_after_fall", 5'h08, edge_after_fall);
    wr("w1c_edge_all", 5'h08, 32'hFF);
    rd("edge_cleared", 5'h08, 32'h00);

    wr("dev_wr_3c", 5'h0C, 32'h3C);
    check("dev_out_3c", 32'(Device_Out), 32'h3C);
    check("dev_valid_set", 32'(Device_Valid), 32'd1);
    rd("status_busy", 5'h10, 32'h1);
    wr("dev_wr_55_ovf", 5'h0C, 32'h55);
    rd("status_busy_ovf", 5'h10, 32'h3);
    check("dev_out_held", 32'(Device_Out), 32'h3C);
    rd("rd_dev_data", 5'h0C, 32'h3C);
    Device_Ack = 1'b1;
    @(negedge clk);
    Device_Ack = 1'b0;
    check("dev_valid_after_ack", 32'(Device_Valid), 32'd0);
    rd("status_ovf_only", 5'h10, 32'h2);
    wr("w1c_ovf", 5'h10, 32'h2);
    rd("status_clear", 5'h10, 32'h0);
    Device_Ack = 1'b1;
    @(negedge clk);
    Device_Ack = 1'b0;
    check("ack_idle_ignored", 32'(Device_Valid), 32'd0);

    // Rising edge on bit 0 lands on the same edge as the W1C of bit 0.
    GPIO_In = 8'h01;
    idle(2);
    wr("w1c_vs_edge", 5'h08, 32'h01);
    rd("edge_set_wins", 5'h08, 32'h01);

    wr("dev_wr_11", 5'h0C, 32'h11);
    Device_Ack = 1'b1;
    wr("dev_ack_wr_77", 5'h0C, 32'h77);
    Device_Ack = 1'b0;
    check("dev_out_77", 32'(Device_Out), 32'h77);
    check("dev_valid_77", 32'(Device_Valid), 32'd1);
    rd("status_no_ovf", 5'h10, 32'h1);

    // Reset asserted together with a request: no Ready, pending byte dropped.
    idle(1);
    reset = 1'b1; Sel = 1'b1; Mem_Read = 1'b1; Addr = 5'h0C;
    @(negedge clk);
    Sel = 1'b0; Mem_Read = 1'b0;
    check("rst_abort_ready", 32'(Ready), 32'd0);
    check("rst_abort_valid", 32'(Device_Valid), 32'd0);
    check("rst_abort_rdata", Read_Data, 32'h0);
    reset = 1'b0;
    rd("rd_dev_after_rst", 5'h0C, 32'h0);
    check("gpio_out_after_rst", 32'(GPIO_Out), 32'h00);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
